scan_chain_controller: RTL and testbench
========================================

Name: scan_chain_controller

Overview:
- Drives one mux-D scan chain built from scan cells with ports d/si/se/clk/reset/so. This block is the tester side that feeds scan_si and scan_se and reads scan_so.
- Per start request it runs one sequence: shift a stimulus pattern in, pulse one functional capture cycle, shift the response out, then compare the response against a masked expected value.
- Sits between the scan chain and a test sequencer or CPU register block.

Parameters:
- CHAIN_LEN, 8, number of scan cells in the chain (>=2).
- CNT_W, 4, bit-counter width; must satisfy 2^CNT_W > CHAIN_LEN.

Ports:
- clk  in  1  single clock; scan chain shares it.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- pattern  in  CHAIN_LEN  stimulus; bit i is loaded into cell i (cell 0 is at si, cell CHAIN_LEN-1 drives so).
- expected  in  CHAIN_LEN  expected captured value per cell.
- mask  in  CHAIN_LEN  1 = don't-care bit, excluded from compare.
- scan_se  out  1  scan enable to chain; registered.
- scan_si  out  1  serial data to chain; registered.
- scan_so  in  1  serial data from chain (last cell output).
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the result is valid.
- pass  out  1  compare result; held until the next accepted start.
- captured  out  CHAIN_LEN  unloaded response; bit i comes from cell i.

Behaviour:
- Reset (async, immediate): state=IDLE; scan_se=0, scan_si=0, busy=0, done=0, pass=0, captured=0, counter=0.
- FSM states: IDLE -> SHIFT_IN -> CAPTURE -> SHIFT_OUT -> DONE -> IDLE.
- Edge 0: start=1 in IDLE latches pattern, expected and mask.
  - Sets state=SHIFT_IN, busy=1, scan_se=1, scan_si=pattern[CHAIN_LEN-1].
  - Clears pass and captured.
- SHIFT_IN: the chain shifts at edges 1..CHAIN_LEN. The value on scan_si before edge k is pattern[CHAIN_LEN-k]. After edge CHAIN_LEN, cell i holds pattern[i].
- At edge CHAIN_LEN: state=CAPTURE, scan_se=0, scan_si=0.
- CAPTURE lasts exactly 1 cycle. The chain captures d at edge CHAIN_LEN+1. At that edge the controller sets state=SHIFT_OUT and scan_se=1; scan_si is held at 0.
- SHIFT_OUT: at edges CHAIN_LEN+1+j (j=1..CHAIN_LEN), scan_so is sampled into captured[CHAIN_LEN-j]. The chain shifts on the same edges.
- At edge 2*CHAIN_LEN+1: state=DONE, scan_se=0, busy=0, done=1.
  - pass = ((captured ^ expected_latched) & ~mask_latched) == 0, computed with the final sampled bit included.
  - done stays high for exactly one cycle, then state=IDLE.
- Latency: done is high in the cycle after edge 2*CHAIN_LEN+1 counted from the start-accept edge (17 edges for the default).
- start while busy or in DONE is ignored; there is no queueing.
- start is accepted in IDLE in the cycle immediately after DONE.
- Changes on pattern, expected or mask after acceptance have no effect.
- Reset asserted mid-sequence aborts at once: scan_se drops to 0 and chain contents are undefined. The next start runs a full, correct sequence.
- mask = all ones forces pass=1.
- Counter counts 0..CHAIN_LEN-1 in each shift phase and is reused between phases; it must not wrap into a stray extra shift.

Test Plan:
- Chain model for all tests: CHAIN_LEN=8 scan cells with d_i = ~q_i. Expected capture = ~pattern.
- Happy path: reset, then start with pattern=8'hA5, expected=8'h5A, mask=0.
  - scan_si sequence is 1,0,1,0,0,1,0,1.
  - scan_se is 1 for 8 cycles, 0 for 1 cycle, then 1 for 8 cycles.
  - done pulses once 17 edges after accept; captured=8'h5A, pass=1.
- Mismatch: pattern=8'hA5, expected=8'h5B, mask=0 -> captured=8'h5A, pass=0. Rerun with mask=8'h01 -> pass=1.
- Busy rejection: pulse start again at edges 3 and 12 of a sequence with pattern=8'hFF.
  - No restart; exactly one done pulse, still at edge 17.
  - captured=8'h00.
- Back-to-back: start held high continuously with pattern=8'h0F then 8'hF0.
  - Second accept occurs the cycle after DONE.
  - captured goes 8'hF0, then 8'h0F; pass=1 both times.
- Reset mid-op: assert reset between edges 4 and 5 of SHIFT_IN.
  - Outputs go to 0 immediately (scan_se=0, busy=0, done never pulses).
  - After release, start with pattern=8'h3C -> captured=8'hC3, pass=1.
- Input change: change pattern and expected to 8'h00 at edge 2 after accepting pattern=8'h81, expected=8'h7E -> captured=8'h7E, pass=1.

Source files
------------

// File: rtl/scan_chain_controller.sv
// scan_chain_controller: loads a pattern into a mux-D scan chain, captures once, unloads and compares under a mask
module scan_chain_controller #(
    parameter int CHAIN_LEN = 8,
    parameter int CNT_W     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] pattern,
    input  logic [CHAIN_LEN-1:0] expected,
    input  logic [CHAIN_LEN-1:0] mask,
    output logic                 scan_se,
    output logic                 scan_si,
    input  logic                 scan_so,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CHAIN_LEN-1:0] captured
);
    typedef enum logic [2:0] {IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE} state_t;
    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CHAIN_LEN-1:0] pat_q, pat_d, exp_q, exp_d, mask_q, mask_d, cap_q, cap_d;
    logic                 se_q, se_d, si_q, si_d, busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic                 last;
    logic [CHAIN_LEN-1:0] cap_shift;
    assign last      = cnt_q == CNT_W'(CHAIN_LEN - 1);
    assign cap_shift = {cap_q[CHAIN_LEN-2:0], scan_so};
    assign scan_se   = se_q;
    assign scan_si   = si_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign captured  = cap_q;
    // Sequence control: pat_q holds the not-yet-sent bits MSB first; cap_q fills MSB first from scan_so
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        exp_d   = exp_q;
        mask_d  = mask_q;
        cap_d   = cap_q;
        se_d    = se_q;
        si_d    = si_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = SHIFT_IN;
                pat_d   = {pattern[CHAIN_LEN-2:0], 1'b0};
                exp_d   = expected;
                mask_d  = mask;
                si_d    = pattern[CHAIN_LEN-1];
                se_d    = 1'b1;
                busy_d  = 1'b1;
                pass_d  = 1'b0;
                cap_d   = '0;
                cnt_d   = '0;
            end
            SHIFT_IN: begin
                pat_d   = {pat_q[CHAIN_LEN-2:0], 1'b0};
                state_d = last ? CAPTURE : SHIFT_IN;
                se_d    = !last;
                si_d    = last ? 1'b0 : pat_q[CHAIN_LEN-1];
                cnt_d   = last ? '0 : cnt_q + CNT_W'(1);
            end
            CAPTURE: begin
                state_d = SHIFT_OUT;
                se_d    = 1'b1;
            end
            SHIFT_OUT: begin
                cap_d   = cap_shift;
                state_d = last ? DONE : SHIFT_OUT;
                se_d    = !last;
                busy_d  = !last;
                done_d  = last;
                pass_d  = last ? (((cap_shift ^ exp_q) & ~mask_q) == '0) : pass_q;
                cnt_d   = last ? '0 : cnt_q + CNT_W'(1);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // State and output registers, cleared immediately on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pat_q   <= '0;
            exp_q   <= '0;
            mask_q  <= '0;
            cap_q   <= '0;
            se_q    <= 1'b0;
            si_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
            exp_q   <= exp_d;
            mask_q  <= mask_d;
            cap_q   <= cap_d;
            se_q    <= se_d;
            si_q    <= si_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end
endmodule

// File: tb/tb_scan_chain_controller.sv
// tb_scan_chain_controller: drives the controller against a scan chain of inverting cells and checks a reference model
module tb_scan_chain_controller;
    localparam int N = 8;
    logic         clk = 1'b0, reset = 1'b0, start = 1'b0;
    logic [N-1:0] pattern = '0, expected = '0, mask = '0;
    logic         scan_se, scan_si, scan_so, busy, done, pass;
    logic [N-1:0] captured;
    logic [N-1:0] chain = '0;
    int           n_checks = 0, n_fail = 0;

    scan_chain_controller #(.CHAIN_LEN(N), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .pattern(pattern), .expected(expected), .mask(mask),
        .scan_se(scan_se), .scan_si(scan_si), .scan_so(scan_so), .busy(busy), .done(done), .pass(pass),
        .captured(captured)
    );

    always #5 clk = ~clk;

    // Scan chain: cell 0 at si, cell N-1 drives so; functional d of each cell is its own inverse
    assign scan_so = chain[N-1];
    always @(posedge clk) chain <= scan_se ? {chain[N-2:0], scan_si} : ~chain;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full sequence; expected capture of an inverting chain is ~pattern
    task automatic run(input logic [N-1:0] p, input logic [N-1:0] e, input logic [N-1:0] m,
                       input bit hold, input bit poke, input bit chg);
        logic [N-1:0] exp_cap;
        logic         exp_pass;
        exp_cap  = ~p;
        exp_pass = ((exp_cap ^ e) & ~m) == '0;
        pattern  = p;
        expected = e;
        mask     = m;
        start    = 1'b1;
        step();
        start = hold;
        chk("accept_busy", busy, 1);
        chk("accept_pass_clr", pass, 0);
        chk("accept_cap_clr", captured, 0);
        for (int k = 1; k <= 2 * N + 1; k++) begin
            if (poke) start = (k == 3 || k == 12);
            if (chg && k == 2) begin
                pattern  = '0;
                expected = '0;
            end
            chk($sformatf("se@%0d", k), scan_se, (k == N + 1) ? 0 : 1);
            chk($sformatf("si@%0d", k), scan_si, (k <= N) ? p[N-k] : 1'b0);
            chk($sformatf("busy@%0d", k), busy, 1);
            chk($sformatf("done@%0d", k), done, 0);
            step();
        end
        if (poke) start = 1'b0;
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_se", scan_se, 0);
        chk("captured", captured, exp_cap);
        chk("pass", pass, exp_pass);
        step();
        chk("after_done", done, 0);
        chk("after_busy", busy, 0);
        chk("pass_held", pass, exp_pass);
        chk("cap_held", captured, exp_cap);
    endtask

    initial begin
        #2 reset = 1'b1;
        #1;
        chk("rst_se", scan_se, 0);
        chk("rst_si", scan_si, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_cap", captured, 0);
        step();
        reset = 1'b0;
        step();
        run(8'hA5, 8'h5A, 8'h00, 0, 0, 0);
        run(8'hA5, 8'h5B, 8'h00, 0, 0, 0);
        run(8'hA5, 8'h5B, 8'h01, 0, 0, 0);
        run(8'h33, 8'h00, 8'hFF, 0, 0, 0);
        run(8'hFF, 8'h00, 8'h00, 0, 1, 0);
        run(8'h0F, 8'hF0, 8'h00, 1, 0, 0);
        run(8'hF0, 8'h0F, 8'h00, 1, 0, 0);
        start = 1'b0;
        step();
        run(8'h81, 8'h7E, 8'h00, 0, 0, 1);
        pattern = 8'h55;
        start   = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 4; k++) step();
        #2 reset = 1'b1;
        #1;
        chk("midrst_se", scan_se, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_pass", pass, 0);
        chk("midrst_cap", captured, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rst_hold_done", done, 0);
            chk("rst_hold_se", scan_se, 0);
        end
        reset = 1'b0;
        step();
        chk("post_rst_busy", busy, 0);
        run(8'h3C, 8'hC3, 8'h00, 0, 0, 0);
        for (int r = 0; r < 6; r++) begin
            logic [N-1:0] p, e, m;
            p = N'($urandom);
            e = $urandom_range(0, 1) ? ~p : N'($urandom);
            m = (r == 5) ? '1 : (N'($urandom) & N'($urandom));
            run(p, e, m, 0, 0, 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
